p_adder: RTL and testbench
==========================

P_ADDER -- requirements
Module: p_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand/sum width in bits; SHALL support any power of two from 4 to 64.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: a  input  WIDTH  addend A, unsigned.
REQ-005 Port: b  input  WIDTH  addend B, unsigned.
REQ-006 Port: cin  input  1  carry-in, weight 2^0.
REQ-007 Port: s  output  WIDTH  registered sum, bits [WIDTH-1:0] of a+b+cin.
REQ-008 Port: cout  output  1  registered carry-out, bit WIDTH of a+b+cin.
REQ-009 Ports SHALL be declared in the order clk, rst, a, b, cin, s, cout.

Function
REQ-010 {cout, s} SHALL equal a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
REQ-011 Carry computation SHALL use a parallel-prefix (Kogge-Stone) network, not a single behavioural '+' operator.
REQ-012 Per-bit pre-processing: g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
REQ-013 Carry-in SHALL be merged as a generate term at position -1: G[-1] = cin, P[-1] = 0.
REQ-014 Prefix network: log2(WIDTH) levels; at level k, each node i with i - 2^k >= -1 combines (G,P)[i] with (G,P)[i-2^k] via G = Gh | (Ph & Gl), P = Ph & Pl; all other nodes pass through unchanged.
REQ-015 Post-processing: c[i] = group-generate over bits [i-1:-1]; s[i] = p[i] ^ c[i]; cout = group-generate over bits [WIDTH-1:-1].
REQ-016 Inputs a, b, cin SHALL feed the prefix logic combinationally; s and cout SHALL be captured in flops on the rising clk edge.
REQ-017 Latency: exactly 1 cycle; operands present before edge N appear on s/cout after edge N and hold until the next edge.
REQ-018 Throughput: one new operand set accepted every cycle, with no handshake and no stall.
REQ-019 Full carry propagation (all p[i] = 1) SHALL resolve within the single cycle, with no multi-cycle path.
REQ-020 Overflow wrap: s SHALL wrap modulo 2^WIDTH, with the excess reported only on cout.

Reset
REQ-021 While rst = 1, s SHALL be 0 and cout SHALL be 0, asynchronously, independent of clk.
REQ-022 rst asserted mid-stream SHALL clear outputs immediately; the in-flight result SHALL be discarded.
REQ-023 After rst deasserts, the first rising edge SHALL capture the then-current a+b+cin.
REQ-024 The block SHALL have no state other than the s/cout registers.

Verification
REQ-025 Reset: assert rst with a = FFFFFFFF, b = FFFFFFFF, cin = 1 -> s = 00000000, cout = 0 immediately, without a clock edge.
REQ-026 Basic: a = 00000000, b = 00000000, cin = 0 -> s = 00000000, cout = 0; then a = 00000001, b = 00000001, cin = 0 -> s = 00000002, cout = 0 one cycle later.
REQ-027 Wrap: a = FFFFFFFF, b = 00000001, cin = 0 -> s = 00000000, cout = 1.
REQ-028 Propagate chain: a = AAAAAAAA, b = 55555555, cin = 0 -> s = FFFFFFFF, cout = 0; the same operands with cin = 1 -> s = 00000000, cout = 1.
REQ-029 Carry-in path: a = 12345678, b = 87654321, cin = 1 -> s = 9999999A, cout = 0; a = FFFFFFFF, b = FFFFFFFF, cin = 1 -> s = FFFFFFFF, cout = 1.
REQ-030 Random and pipelined: at least 10000 random back-to-back vectors, each result checked against a WIDTH+1-bit reference sum one cycle later; repeat at WIDTH = 8 and WIDTH = 64.

Source files
------------

// File: rtl/p_adder.sv
// Registered WIDTH-bit adder with carry-in and carry-out. The carries come from a
// Kogge-Stone parallel-prefix network, so the longest carry chain resolves in log2(WIDTH) levels.
module p_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);

    // Node index j holds bit position j-1. Index 0 is position -1 and carries cin.
    logic [WIDTH:0] g0;
    logic [WIDTH:1] p0;

    assign g0 = {a & b, cin};
    assign p0 = a ^ b;

    // Any group that reaches position -1 has a propagate of 0, because P[-1] = 0.
    // Each level therefore stores propagate only for nodes that have not yet reached index 0.
    // After level k, these are the nodes at index 2^(k+1) and above.
    genvar gk, gi;
    generate
        for (gk = 0; gk < LEVELS; gk++) begin : lvl
            logic [WIDTH:0]          gin;
            logic [WIDTH:(1 << gk)]  pin;
            logic [WIDTH:0]          g;
            logic [WIDTH:(2 << gk)]  p;

            if (gk == 0) begin : src_first
                assign gin = g0;
                assign pin = p0;
            end else begin : src_prev
                assign gin = lvl[gk-1].g;
                assign pin = lvl[gk-1].p;
            end

            for (gi = 0; gi <= WIDTH; gi++) begin : node
                if (gi >= (1 << gk)) begin : merge
                    assign g[gi] = gin[gi] | (pin[gi] & gin[gi-(1 << gk)]);
                    if (gi >= (2 << gk)) begin : merge_p
                        assign p[gi] = pin[gi] & pin[gi-(1 << gk)];
                    end
                end else begin : pass
                    assign g[gi] = gin[gi];
                end
            end
        end
    endgenerate

    logic [WIDTH:0]   g_final;
    logic             p_top;
    logic [WIDTH-1:0] s_next;
    logic             cout_next;

    assign g_final = lvl[LEVELS-1].g;
    assign p_top   = lvl[LEVELS-1].p[WIDTH];

    // g_final[i] is the carry into bit i.
    // The top node spans only bits [WIDTH-1:0], so one more merge folds cin into the carry-out.
    assign s_next    = p0 ^ g_final[WIDTH-1:0];
    assign cout_next = g_final[WIDTH] | (p_top & cin);

    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg    <= '0;
            cout_reg <= 1'b0;
        end else begin
            s_reg    <= s_next;
            cout_reg <= cout_next;
        end
    end

    assign s    = s_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_p_adder.sv
// Bench for p_adder at WIDTH = 8, 32 and 64.
// It runs directed vectors at 32 bits, then random back-to-back traffic checked against plain wide arithmetic.
module tb_p_adder;

    localparam int NRAND = 10000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [7:0]  a8,  b8,  s8;
    logic        cin8, cout8;
    logic [31:0] a32, b32, s32;
    logic        cin32, cout32;
    logic [63:0] a64, b64, s64;
    logic        cin64, cout64;

    always #5 clk = ~clk;

    p_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .s(s8), .cout(cout8)
    );
    p_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .cin(cin32), .s(s32), .cout(cout32)
    );
    p_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .a(a64), .b(b64), .cin(cin64), .s(s64), .cout(cout64)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int idx, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, required %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive32(input logic [31:0] va, input logic [31:0] vb, input logic vc);
        a32   = va;
        b32   = vb;
        cin32 = vc;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        cout;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0]  e8;
        logic [32:0] e32;
        logic [64:0] e64;

        vecs[0] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[1] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[3] = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0};
        vecs[4] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1};
        vecs[5] = '{32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[8] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
        vecs[9] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};

        a8 = '1;  b8 = '1;  cin8 = 1'b1;
        a64 = '1; b64 = '1; cin64 = 1'b1;
        drive32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

        // Reset takes effect with no clock edge.
        #1 rst = 1'b1;
        #2;
        check("reset_async32", 0, 65'({cout32, s32}), 65'd0);
        check("reset_async8",  0, 65'({cout8, s8}),   65'd0);
        check("reset_async64", 0, 65'({cout64, s64}), 65'd0);
        $display("txn reset: s32=%h cout32=%b", s32, cout32);

        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_held32", 0, 65'({cout32, s32}), 65'd0);

        // The first edge after reset captures the current operands.
        @(negedge clk);
        rst = 1'b0;
        drive32(32'd5, 32'd7, 1'b1);
        @(posedge clk);
        #1;
        check("first_after_reset", 0, 65'({cout32, s32}), 65'd13);
        $display("txn first: a=%h b=%h cin=%b -> s=%h cout=%b", a32, b32, cin32, s32, cout32);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive32(vecs[i].a, vecs[i].b, vecs[i].cin);
            @(posedge clk);
            #1;
            check("table", i, 65'({cout32, s32}), 65'({vecs[i].cout, vecs[i].s}));
            $display("txn table %0d: a=%h b=%h cin=%b -> s=%h cout=%b", i, vecs[i].a, vecs[i].b, vecs[i].cin, s32, cout32);
        end

        // Assert reset mid-stream, between clock edges.
        @(negedge clk);
        drive32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        @(posedge clk);
        #1;
        check("pre_midreset", 0, 65'({cout32, s32}), 65'({1'b1, 32'hFFFFFFFF}));
        #2 rst = 1'b1;
        #1;
        check("midreset_clear", 0, 65'({cout32, s32}), 65'd0);
        $display("txn midreset: s32=%h cout32=%b", s32, cout32);
        @(negedge clk);
        rst = 1'b0;
        drive32(32'd1, 32'd2, 1'b0);
        @(posedge clk);
        #1;
        check("after_midreset", 0, 65'({cout32, s32}), 65'd3);
        $display("txn after midreset: a=%h b=%h -> s=%h cout=%b", a32, b32, s32, cout32);

        // Random back-to-back traffic: a new operand set every cycle.
        // Each result is checked one cycle after its operands were driven.
        e8 = '0; e32 = '0; e64 = '0;
        for (int i = 0; i <= NRAND; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("rand8",  i - 1, 65'({cout8, s8}),   65'(e8));
                check("rand32", i - 1, 65'({cout32, s32}), 65'(e32));
                check("rand64", i - 1, 65'({cout64, s64}), e64);
            end
            if (i < NRAND) begin
                a8  = 8'($urandom);
                b8  = 8'($urandom);
                a32 = $urandom;
                b32 = $urandom;
                a64 = {$urandom, $urandom};
                b64 = {$urandom, $urandom};
                cin8  = 1'($urandom);
                cin32 = 1'($urandom);
                cin64 = 1'($urandom);
                case ($urandom_range(0, 7))
                    0: begin b8 = ~a8; b32 = ~a32; b64 = ~a64; end
                    1: begin a8 = '1;  a32 = '1;   a64 = '1;   end
                    default: ;
                endcase
                e8  = 9'(a8)   + 9'(b8)   + 9'(cin8);
                e32 = 33'(a32) + 33'(b32) + 33'(cin32);
                e64 = 65'(a64) + 65'(b64) + 65'(cin64);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
